// File: rtl/nasti_stream_arbiter_if.sv
// nasti_stream_channel: NASTI-stream (AXI4-stream style) channel bundle.
interface nasti_stream_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DATA_WIDTH = 64
) ();
    logic                    t_valid;
    logic                    t_ready;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic                    t_last;
    logic [ID_WIDTH-1:0]     t_id;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/nasti_stream_arbiter.sv
// nasti_stream_arbiter: round-robin N-to-1 NASTI-stream packet arbiter.
// The grant is locked from arbitration until the granted source's t_last beat fires.
module nasti_stream_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DATA_WIDTH = 64,
    localparam int IDX_WIDTH = $clog2(N_PORTS)
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [N_PORTS-1:0]                s_valid,
    output logic [N_PORTS-1:0]                s_ready,
    input  logic [N_PORTS*DATA_WIDTH-1:0]     s_data,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0]   s_strb,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0]   s_keep,
    input  logic [N_PORTS-1:0]                s_last,
    input  logic [N_PORTS*ID_WIDTH-1:0]       s_id,
    input  logic [N_PORTS*DEST_WIDTH-1:0]     s_dest,
    input  logic [N_PORTS*USER_WIDTH-1:0]     s_user,
    nasti_stream_channel.master               m,
    output logic                              busy,
    output logic [IDX_WIDTH-1:0]              grant_idx
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  grant_q, grant_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  m_valid;

    logic [DATA_WIDTH-1:0]   data_a [N_PORTS];
    logic [DATA_WIDTH/8-1:0] strb_a [N_PORTS];
    logic [DATA_WIDTH/8-1:0] keep_a [N_PORTS];
    logic [ID_WIDTH-1:0]     id_a   [N_PORTS];
    logic [DEST_WIDTH-1:0]   dest_a [N_PORTS];
    logic [USER_WIDTH-1:0]   user_a [N_PORTS];

    for (genvar g = 0; g < N_PORTS; g++) begin : g_src
        assign data_a[g] = s_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign strb_a[g] = s_strb[g*(DATA_WIDTH/8) +: DATA_WIDTH/8];
        assign keep_a[g] = s_keep[g*(DATA_WIDTH/8) +: DATA_WIDTH/8];
        assign id_a[g]   = s_id[g*ID_WIDTH +: ID_WIDTH];
        assign dest_a[g] = s_dest[g*DEST_WIDTH +: DEST_WIDTH];
        assign user_a[g] = s_user[g*USER_WIDTH +: USER_WIDTH];
    end

    function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                                     input logic [IDX_WIDTH-1:0] ptr);
        logic [IDX_WIDTH-1:0] j;
        rr_pick = ptr;
        // Scan downward so the requester nearest to ptr is the last to overwrite, and wins.
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            j = IDX_WIDTH'((int'(ptr) + i) % N_PORTS);
            if (req[j]) rr_pick = j;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        s_ready  = '0;
        m_valid  = 1'b0;
        if (state_q == IDLE) begin
            if (|s_valid) begin
                grant_d = rr_pick(s_valid, rr_ptr_q);
                state_d = BUSY;
            end
        end else begin
            m_valid          = s_valid[grant_q];
            s_ready[grant_q] = m.t_ready;
            if (m_valid && m.t_ready && s_last[grant_q]) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_q == IDX_WIDTH'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign m.t_valid = m_valid;
    assign m.t_data  = data_a[grant_q];
    assign m.t_strb  = strb_a[grant_q];
    assign m.t_keep  = keep_a[grant_q];
    assign m.t_last  = s_last[grant_q];
    assign m.t_id    = id_a[grant_q];
    assign m.t_dest  = dest_a[grant_q];
    assign m.t_user  = user_a[grant_q];
    assign busy      = (state_q == BUSY);
    assign grant_idx = grant_q;
endmodule

// File: tb/tb_nasti_stream_arbiter.sv
// tb_nasti_stream_arbiter: directed and randomized packet traffic against a behavioural arbiter model.
module tb_nasti_stream_arbiter;
    localparam int N = 4;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b1;
    logic [N-1:0]    s_valid, s_ready, s_last, s_id, s_dest, s_user;
    logic [N*64-1:0] s_data;
    logic [N*8-1:0]  s_strb, s_keep;
    logic            busy;
    logic [1:0]      grant_idx;

    nasti_stream_channel #(.ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(64)) bus ();

    nasti_stream_arbiter #(.N_PORTS(N), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(64)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb), .s_keep(s_keep),
        .s_last(s_last), .s_id(s_id), .s_dest(s_dest), .s_user(s_user),
        .m(bus), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 aclk = ~aclk;

    // Source-side stimulus state: the beat each source currently presents.
    logic        sv [N];
    logic [63:0] sd [N];
    logic [7:0]  sst [N], skp [N];
    logic        sl [N], sid [N], sdst [N], su [N];
    int          rem [N];
    logic        mr = 1'b0;
    bit          auto_mode = 1'b0;

    // Behavioural model: who owns the channel, who is next in line, last grant.
    int owner = -1, next_pri = 0, gidx = 0;
    int checks = 0, errors = 0, nfires = 0;
    logic [31:0] fire_log = '0, pkt_log = '0;
    logic [63:0] last_fire_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            s_valid[i]         = sv[i];
            s_data[i*64 +: 64] = sd[i];
            s_strb[i*8 +: 8]   = sst[i];
            s_keep[i*8 +: 8]   = skp[i];
            s_last[i]          = sl[i];
            s_id[i]            = sid[i];
            s_dest[i]          = sdst[i];
            s_user[i]          = su[i];
        end
        bus.t_ready = mr;
    endtask

    task automatic fill(input int i, input logic [63:0] base);
        sd[i]   = base;
        sst[i]  = base[7:0];
        skp[i]  = ~base[7:0];
        sid[i]  = base[0];
        sdst[i] = base[1];
        su[i]   = base[2];
        sl[i]   = (rem[i] == 1);
    endtask

    task automatic load(input int i, input int n, input logic [63:0] base);
        rem[i] = n;
        fill(i, base);
        sv[i] = 1'b1;
    endtask

    // Requester with the smallest rotational distance from next_pri wins.
    function automatic int pick();
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++)
            if (sv[i] && (i - next_pri + N) % N < bd) begin
                bd = (i - next_pri + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic step();
        int f;
        logic exp_v, dut_fire;
        @(negedge aclk);
        apply();
        #1;
        exp_v = (owner >= 0) ? sv[owner] : 1'b0;
        chk("busy", busy, owner >= 0);
        chk("grant_idx", grant_idx, 64'(gidx));
        chk("m_valid", bus.t_valid, exp_v);
        chk("s_ready", s_ready, (owner >= 0) ? (64'(mr) << owner) : 64'd0);
        if (exp_v) begin
            chk("t_data", bus.t_data, sd[owner]);
            chk("t_strb", bus.t_strb, sst[owner]);
            chk("t_keep", bus.t_keep, skp[owner]);
            chk("t_last", bus.t_last, sl[owner]);
            chk("t_id", bus.t_id, sid[owner]);
            chk("t_dest", bus.t_dest, sdst[owner]);
            chk("t_user", bus.t_user, su[owner]);
        end
        dut_fire = bus.t_valid & bus.t_ready;
        fire_log = {fire_log[30:0], dut_fire};
        if (dut_fire) begin
            nfires++;
            last_fire_data = bus.t_data;
            if (bus.t_last) pkt_log = {pkt_log[27:0], 2'b00, grant_idx};
        end
        f = (exp_v && mr) ? owner : -1;
        if (owner < 0) begin
            owner = pick();
            if (owner >= 0) gidx = owner;
        end else if (f >= 0 && sl[f]) begin
            next_pri = (owner + 1) % N;
            owner = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (i == f) begin
                rem[i]--;
                if (rem[i] > 0) begin
                    fill(i, auto_mode ? {$urandom, $urandom} : sd[i] + 64'd1);
                    sv[i] = auto_mode ? ($urandom % 4 != 0) : 1'b1;
                end else sv[i] = 1'b0;
            end else if (auto_mode && !sv[i]) begin
                if (rem[i] == 0 && $urandom % 6 == 0) load(i, $urandom_range(1, 4), {$urandom, $urandom});
                else if (rem[i] > 0 && $urandom % 2 == 0) sv[i] = 1'b1;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic rst_pulse();
        aresetn = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", bus.t_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_idx", grant_idx, 0);
        owner = -1;
        next_pri = 0;
        gidx = 0;
        fire_log = '0;
        pkt_log = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            sv[i] = 1'b0;
            fill(i, 64'd0);
        end
        apply();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            sv[i] = 1'b0;
            fill(i, 64'd0);
        end
        apply();
        #2;
        rst_pulse();

        // Single 3-beat packet from source 2, then rotation continues at 3.
        mr = 1'b1;
        load(2, 3, 64'h200);
        repeat (5) step();
        chk("s1_fire_pattern", fire_log[4:0], 5'b01110);
        chk("s1_grant", grant_idx, 2);
        chk("s1_busy_after", busy, 0);
        load(0, 1, 64'h10);
        load(3, 1, 64'h30);
        step();
        chk("s1_next_grant", grant_idx, 3);
        chk("s1_next_busy", busy, 1);
        repeat (4) step();
        chk("s1_pkt_order", pkt_log[11:0], 12'h230);

        // All four sources with 2-beat packets: strict rotation with one idle bubble each.
        rst_pulse();
        for (int i = 0; i < N; i++) load(i, 2, 64'(i) << 8);
        repeat (12) step();
        chk("s2_fire_pattern", fire_log[11:0], 12'b011011011011);
        chk("s2_pkt_order", pkt_log[15:0], 16'h0123);
        load(0, 2, 64'h1000);
        load(2, 2, 64'h2000);
        repeat (6) step();
        chk("s2_wrap_order", pkt_log[23:0], 24'h012302);

        // Granted source 1 stalls mid-packet while source 0 waits.
        rst_pulse();
        load(1, 4, 64'h100);
        step();
        load(0, 1, 64'h0A0);
        step();
        sv[1] = 1'b0;
        repeat (3) step();
        chk("s3_grant_held", grant_idx, 1);
        chk("s3_busy_held", busy, 1);
        sv[1] = 1'b1;
        repeat (5) step();
        chk("s3_fire_pattern", fire_log[9:0], 10'b0100011101);
        chk("s3_pkt_order", pkt_log[7:0], 8'h10);

        // Downstream backpressure toggling on a 4-beat packet from source 3.
        rst_pulse();
        load(3, 4, 64'h300);
        mr = 1'b0;
        step();
        for (int k = 0; k < 7; k++) begin
            mr = (k % 2 == 0);
            step();
        end
        chk("s4_fire_pattern", fire_log[7:0], 8'b01010101);
        chk("s4_pkt_order", pkt_log[3:0], 4'h3);
        chk("s4_last_data", last_fire_data, 64'h303);

        // Back-to-back single-beat packets from source 0 only.
        rst_pulse();
        mr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (rem[0] == 0) load(0, 1, 64'h500 + 64'(k));
            step();
        end
        chk("s5_fire_pattern", fire_log[7:0], 8'b01010101);
        chk("s5_grant", grant_idx, 0);

        // Reset in the middle of a packet drops the lock and the rotation pointer.
        rst_pulse();
        load(2, 1, 64'h600);
        repeat (2) step();
        chk("s6_first_grant", grant_idx, 2);
        load(3, 4, 64'h700);
        repeat (2) step();
        @(negedge aclk);
        apply();
        #1;
        chk("s6_mid_valid", bus.t_valid, 1);
        rst_pulse();
        load(1, 2, 64'h800);
        load(3, 4, 64'h700);
        step();
        chk("s6_fresh_grant", grant_idx, 1);
        repeat (7) step();
        chk("s6_pkt_order", pkt_log[7:0], 8'h13);

        // Randomized traffic with random backpressure and occasional resets.
        rst_pulse();
        auto_mode = 1'b1;
        nfires = 0;
        for (int k = 0; k < 4000; k++) begin
            mr = ($urandom % 4 != 0);
            if ($urandom_range(0, 1499) == 0) rst_pulse();
            step();
        end
        chk("rand_progress", nfires > 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nasti_stream_arbiter.md
Name: nasti_stream_arbiter

Overview:
- N-to-1 packet arbiter for NASTI-stream traffic.
- Shares one downstream stream channel, typically a stream buffer or DMA sink, between N_PORTS upstream sources.
- Rotating-priority (round-robin) grant, locked for a whole packet, i.e. until the t_last beat completes.
- Datapath is a zero-latency combinational mux from the granted source; control is a registered FSM.

Parameters:
- N_PORTS, 4, number of upstream sources (2..16).
- ID_WIDTH, 1, t_id width.
- DEST_WIDTH, 1, t_dest width.
- USER_WIDTH, 1, t_user width.
- DATA_WIDTH, 64, t_data width (multiple of 8).
- IDX_WIDTH, $clog2(N_PORTS), grant index width (localparam).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_valid  in  N_PORTS  per-source t_valid.
- s_ready  out  N_PORTS  per-source t_ready.
- s_data  in  N_PORTS*DATA_WIDTH  packed t_data; source i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_strb  in  N_PORTS*DATA_WIDTH/8  packed t_strb.
- s_keep  in  N_PORTS*DATA_WIDTH/8  packed t_keep.
- s_last  in  N_PORTS  per-source t_last.
- s_id  in  N_PORTS*ID_WIDTH  packed t_id.
- s_dest  in  N_PORTS*DEST_WIDTH  packed t_dest.
- s_user  in  N_PORTS*USER_WIDTH  packed t_user.
- m  nasti_stream_channel.master  –  downstream channel.
- busy  out  1  high while a packet is granted.
- grant_idx  out  IDX_WIDTH  index of the current or last granted source.

Behaviour:
- State
  - Two states: IDLE and BUSY.
  - Registers: state, grant (IDX_WIDTH), rr_ptr (IDX_WIDTH).
- Reset (aresetn low, async)
  - state=IDLE, grant=0, rr_ptr=0.
  - Outputs: s_ready=0, m.t_valid=0, busy=0, grant_idx=0.
  - Reset mid-packet drops the lock immediately; the partial packet is not completed, and the upstream must re-send.
- IDLE
  - s_ready all 0; m.t_valid=0.
  - If any s_valid bit is set, pick the first set index scanning rr_ptr, rr_ptr+1, …, wrapping modulo N_PORTS.
  - grant<=index, state<=BUSY.
  - One-cycle arbitration latency: the first beat can transfer at earliest in the cycle after s_valid is seen in IDLE.
- BUSY
  - m.t_valid = s_valid[grant]; s_ready[grant] = m.t_ready; all other s_ready = 0.
  - m.t_data/strb/keep/last/id/dest/user = granted source's fields, combinational.
  - A beat fires when m.t_valid && m.t_ready.
  - Fire with t_last=1: state<=IDLE, rr_ptr <= (grant==N_PORTS-1) ? 0 : grant+1.
  - Fire with t_last=0 or no fire: stay BUSY. The grant is held even if the granted source drops s_valid mid-packet (bubbles allowed); other sources are never interleaved.
  - Single-beat packet (t_last on first beat): one BUSY cycle if m.t_ready=1, then IDLE.
- Handshake rules
  - m.t_valid never depends on m.t_ready.
  - s_ready of a non-granted source is always 0.
  - A source that has asserted s_valid must hold it and its data stable until s_ready (AXI-stream rule).
  - The arbiter does not reorder or modify any field.
- Fairness: after source k completes a packet it has lowest priority. With all sources requesting continuously, grants go k+1, k+2, …, and each source waits at most N_PORTS-1 packets.
- Outputs
  - busy = (state==BUSY).
  - grant_idx = grant register; it keeps its last value in IDLE.
  - m fields in IDLE reflect source[grant] but m.t_valid=0 (don't-care).

Test Plan:
- Reset, then s_valid=4'b0100, 3-beat packet, m.t_ready=1 → grant_idx=2, beats on m at cycles 1–3 after request, busy drops after beat 3, rr_ptr=3.
- All 4 sources each hold a 2-beat packet, m.t_ready=1 → grant order 0,1,2,3,0; each packet contiguous with no interleaving; IDLE bubble of 1 cycle between packets.
- Granted source 1 deasserts s_valid for 3 cycles mid-packet while source 0 is valid → m.t_valid=0 for those cycles, s_ready[0]=0, grant stays 1 until t_last.
- m.t_ready toggling 1,0,1,0 on a 4-beat packet from source 3 → exactly 4 fires, data order preserved, s_ready[3] mirrors m.t_ready.
- Single-beat packets back-to-back from source 0 only → a fire every 2nd cycle, grant_idx=0 throughout.
- aresetn asserted during beat 2 of 4 → s_ready=0, m.t_valid=0 immediately; after release state=IDLE, rr_ptr=0, and the next grant follows fresh arbitration.
